// File: rtl/xrs_wb_arb_pkg.sv
// Shared constants for the write-back arbiter and its register scoreboard.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package xrs_wb_arb_pkg;

    localparam int XLEN_DEF       = 64;  // register data width
    localparam int REG_AW         = 5;   // register address width
    localparam int NREGS          = 32;  // architectural register count
    localparam int STARVE_MAX_DEF = 3;   // consecutive ALU denials before ALU is forced through

endpackage

// File: rtl/xrs_scoreboard.sv
// Per-register pending flags: set by the decoder at issue, cleared at write-back commit.
// Latency: set/clear become visible on busy one cycle after the request.
// Backpressure: none; set and clear are accepted every cycle, set wins on a same-register collision.
// Ports: clk, rst_n (sync, active-low), set_en/set_rd, clr_en/clr_rd, busy[NREGS-1:0].
module xrs_scoreboard
    import xrs_wb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] busy_nxt;

    // Clear first, then set, so an issue landing on the same register as a
    // commit leaves it pending for the newer producer. Register 0 never pends.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/xrs_wb_arb.sv
// Two-source register-file write-back arbiter (load > ALU, with ALU anti-starvation) plus bypass.
// Latency: granted write appears on rd_o/rdat_o/rwe_o one cycle after transfer; bypass one cycle later.
// Backpressure: at most one ready per cycle; ready depends only on valids and the starvation count.
// Ports: clk_i, reset_ni; a_* (ALU) and b_* (load) valid/ready requests; issue_* scoreboard set;
//        busy_o; rd_o/rdat_o/rwe_o register-file write; ra_i/rb_i read addresses; fwda_o/fwdb_o/fwd_dat_o.
module xrs_wb_arb
    import xrs_wb_arb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              a_valid_i,
    input  logic [REG_AW-1:0] a_rd_i,
    input  logic [XLEN-1:0]   a_dat_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [REG_AW-1:0] b_rd_i,
    input  logic [XLEN-1:0]   b_dat_i,
    output logic              b_ready_o,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    output logic [NREGS-1:0]  busy_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   rdat_o,
    output logic              rwe_o,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic              fwda_o,
    output logic              fwdb_o,
    output logic [XLEN-1:0]   fwd_dat_o
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0]     starve;
    logic              starved;
    logic              a_win;
    logic              b_win;
    logic              xfer;
    logic [REG_AW-1:0] wr_rd;
    logic [XLEN-1:0]   wr_dat;

    assign starved = (starve == SW'(STARVE_MAX));

    // Load has priority; the ALU only overrides once it has been turned away
    // STARVE_MAX times in a row. A lone requester always wins.
    assign a_win     = a_valid_i && (!b_valid_i || starved);
    assign b_win     = b_valid_i && !a_win;
    assign a_ready_o = reset_ni && a_win;
    assign b_ready_o = reset_ni && b_win;

    assign xfer   = a_ready_o || b_ready_o;
    assign wr_rd  = b_ready_o ? b_rd_i  : a_rd_i;
    assign wr_dat = b_ready_o ? b_dat_i : a_dat_i;

    // Counts consecutive cycles the ALU was waiting but denied.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            starve <= '0;
        end else if (!a_valid_i || a_ready_o) begin
            starve <= '0;
        end else if (!starved) begin
            starve <= starve + SW'(1);
        end
    end

    // Register-file write port. Writes to x0 are accepted but never enabled.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rwe_o  <= 1'b0;
            rd_o   <= '0;
            rdat_o <= '0;
        end else if (xfer) begin
            rwe_o  <= (wr_rd != '0);
            rd_o   <= wr_rd;
            rdat_o <= wr_dat;
        end else begin
            rwe_o  <= 1'b0;
        end
    end

    // Bypass: the write being performed this cycle is forwarded next cycle,
    // lining up with the register-file read data for ra_i/rb_i.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            fwda_o    <= 1'b0;
            fwdb_o    <= 1'b0;
            fwd_dat_o <= '0;
        end else begin
            fwda_o    <= rwe_o && (rd_o == ra_i) && (rd_o != '0);
            fwdb_o    <= rwe_o && (rd_o == rb_i) && (rd_o != '0);
            fwd_dat_o <= rdat_o;
        end
    end

    xrs_scoreboard u_sb (
        .clk    (clk_i),
        .rst_n  (reset_ni),
        .set_en (issue_i),
        .set_rd (issue_rd_i),
        .clr_en (xfer),
        .clr_rd (wr_rd),
        .busy   (busy_o)
    );

endmodule

// File: tb/tb_xrs_wb_arb.sv
// Self-checking bench for xrs_wb_arb: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model tracks the one-cycle write port and the further one-cycle bypass stage.
// Backpressure: model decides grants from priority and the count of consecutive ALU denials.
module tb_xrs_wb_arb;

    localparam int XLEN = 64;
    localparam int SM   = 3;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic            a_valid_i, b_valid_i, issue_i;
    logic [4:0]      a_rd_i, b_rd_i, issue_rd_i, ra_i, rb_i;
    logic [XLEN-1:0] a_dat_i, b_dat_i;
    logic            a_ready_o, b_ready_o, rwe_o, fwda_o, fwdb_o;
    logic [31:0]     busy_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] rdat_o, fwd_dat_o;

    always #5 clk_i = ~clk_i;

    xrs_wb_arb #(.XLEN(XLEN), .STARVE_MAX(SM)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .a_valid_i  (a_valid_i),
        .a_rd_i     (a_rd_i),
        .a_dat_i    (a_dat_i),
        .a_ready_o  (a_ready_o),
        .b_valid_i  (b_valid_i),
        .b_rd_i     (b_rd_i),
        .b_dat_i    (b_dat_i),
        .b_ready_o  (b_ready_o),
        .issue_i    (issue_i),
        .issue_rd_i (issue_rd_i),
        .busy_o     (busy_o),
        .rd_o       (rd_o),
        .rdat_o     (rdat_o),
        .rwe_o      (rwe_o),
        .ra_i       (ra_i),
        .rb_i       (rb_i),
        .fwda_o     (fwda_o),
        .fwdb_o     (fwdb_o),
        .fwd_dat_o  (fwd_dat_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_init = 1'b0;
    int              m_denied;          // consecutive cycles ALU waited and lost
    bit [31:0]       m_busy;
    bit              m_rwe;
    bit [4:0]        m_rd;
    bit [XLEN-1:0]   m_rdat;
    bit              m_wvis;            // rd_o/rdat_o contents are defined
    bit              m_fa, m_fb;
    bit [XLEN-1:0]   m_fdat;
    bit              m_fvis;            // fwd_dat_o contents are defined
    bit              m_ag, m_bg;
    bit [4:0]        m_grd;

    // Load wins, except when the ALU has already lost SM times in a row.
    function automatic bit grant_a();
        if (!reset_ni || !a_valid_i) return 1'b0;
        if (!b_valid_i) return 1'b1;
        return m_denied >= SM;
    endfunction

    function automatic bit grant_b();
        if (!reset_ni || !b_valid_i) return 1'b0;
        return !grant_a();
    endfunction

    always @(posedge clk_i) begin
        m_ag = grant_a();
        m_bg = grant_b();
        if (!reset_ni) begin
            m_init   = 1'b1;
            m_denied = 0;
            m_busy   = '0;
            m_rwe    = 1'b0;
            m_rd     = '0;
            m_rdat   = '0;
            m_wvis   = 1'b1;
            m_fa     = 1'b0;
            m_fb     = 1'b0;
            m_fdat   = '0;
            m_fvis   = 1'b1;
        end else begin
            m_fa   = m_rwe && (m_rd == ra_i) && (m_rd != 0);
            m_fb   = m_rwe && (m_rd == rb_i) && (m_rd != 0);
            m_fdat = m_rdat;
            m_fvis = m_wvis;

            if (a_valid_i && !m_ag) m_denied = (m_denied < SM) ? m_denied + 1 : SM;
            else                    m_denied = 0;

            m_grd = m_bg ? b_rd_i : a_rd_i;
            if (m_ag || m_bg) m_busy[m_grd] = 1'b0;
            if (issue_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;

            if (m_ag || m_bg) begin
                m_rwe  = (m_grd != 0);
                m_rd   = m_grd;
                m_rdat = m_bg ? b_dat_i : a_dat_i;
                m_wvis = (m_grd != 0);
            end else begin
                m_rwe  = 1'b0;
                m_wvis = 1'b0;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk_i) begin
        if (m_init) begin
            chk("a_ready", a_ready_o, grant_a());
            chk("b_ready", b_ready_o, grant_b());
            chk("rwe",     rwe_o,     m_rwe);
            chk("busy",    busy_o,    m_busy);
            chk("fwda",    fwda_o,    m_fa);
            chk("fwdb",    fwdb_o,    m_fb);
            if (m_wvis) begin
                chk("rd",   rd_o,   m_rd);
                chk("rdat", rdat_o, m_rdat);
            end
            if (m_fvis) chk("fwd_dat", fwd_dat_o, m_fdat);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        a_valid_i = 0; a_rd_i = 0; a_dat_i = '0;
        b_valid_i = 0; b_rd_i = 0; b_dat_i = '0;
        issue_i = 0; issue_rd_i = 0; ra_i = 0; rb_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_ni = 1'b0;
        idle();
        a_valid_i = 1; a_rd_i = 5; a_dat_i = 64'hDEAD;
        #1;
        chk("rst_a_ready_hold", a_ready_o, 0);
        tick(); tick();
        chk("rst_rwe", rwe_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rdat", rdat_o, 0);
        chk("rst_fwd_dat", fwd_dat_o, 0);
        idle();
        reset_ni = 1'b1;

        // ALU only
        a_valid_i = 1; a_rd_i = 5; a_dat_i = 64'h1122334455667788;
        #1;
        chk("a_only_ready", a_ready_o, 1);
        chk("a_only_b_ready", b_ready_o, 0);
        tick(); idle();
        chk("a_only_rwe", rwe_o, 1);
        chk("a_only_rd", rd_o, 5);
        chk("a_only_rdat", rdat_o, 64'h1122334455667788);
        tick();
        chk("a_only_pulse", rwe_o, 0);

        // Contention: load wins three times, ALU forced on the fourth
        a_valid_i = 1; a_rd_i = 3; a_dat_i = 64'h33;
        b_valid_i = 1; b_rd_i = 4; b_dat_i = 64'h44;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_b_ready", b_ready_o, (i < 3) ? 1'b1 : 1'b0);
            chk("starve_a_ready", a_ready_o, (i < 3) ? 1'b0 : 1'b1);
            tick();
        end
        chk("starve_rd", rd_o, 3);
        #1;
        chk("after_force_b", b_ready_o, 1);
        tick();
        b_valid_i = 0;
        #1;
        chk("b_drop_a_ready", a_ready_o, 1);
        tick(); idle();

        // Scoreboard set/clear
        issue_i = 1; issue_rd_i = 7;
        tick(); idle();
        chk("busy7_set", busy_o[7], 1);
        b_valid_i = 1; b_rd_i = 7;
        tick(); idle();
        chk("busy7_clr", busy_o[7], 0);
        issue_i = 1; issue_rd_i = 9; b_valid_i = 1; b_rd_i = 9;
        tick(); idle();
        chk("busy9_set_wins", busy_o[9], 1);

        // Write to x0
        a_valid_i = 1; a_rd_i = 0; a_dat_i = '1; issue_i = 1; issue_rd_i = 0;
        #1;
        chk("x0_ready", a_ready_o, 1);
        tick(); idle();
        chk("x0_rwe", rwe_o, 0);
        chk("x0_busy", busy_o[0], 0);

        // Bypass
        a_valid_i = 1; a_rd_i = 12; a_dat_i = 64'hABCD;
        tick(); idle();
        ra_i = 12; rb_i = 13;
        chk("fwd_src_rwe", rwe_o, 1);
        tick();
        chk("fwda_hit", fwda_o, 1);
        chk("fwdb_miss", fwdb_o, 0);
        chk("fwd_dat", fwd_dat_o, 64'hABCD);
        idle();

        // Reset mid-operation
        issue_i = 1; issue_rd_i = 20;
        tick(); idle();
        chk("pre_rst_busy", busy_o[20], 1);
        a_valid_i = 1; a_rd_i = 6; a_dat_i = 64'h66;
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_a_ready", a_ready_o, 0);
        tick();
        chk("mid_rst_rwe", rwe_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_rd", rd_o, 0);
        chk("mid_rst_fwda", fwda_o, 0);
        reset_ni = 1'b1;
        #2;
        chk("release_no_pulse", rwe_o, 0);
        tick(); idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset_ni   = ($urandom_range(0, 99) != 0);
            a_valid_i  = ($urandom_range(0, 9) < 7);
            b_valid_i  = ($urandom_range(0, 9) < 6);
            a_rd_i     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            b_rd_i     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a_dat_i    = {$urandom, $urandom};
            b_dat_i    = {$urandom, $urandom};
            issue_i    = ($urandom_range(0, 1) == 1);
            issue_rd_i = 5'($urandom_range(0, 7));
            ra_i       = 5'($urandom_range(0, 7));
            rb_i       = 5'($urandom_range(0, 7));
            tick();
        end

        reset_ni = 1'b1;
        idle();
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
